// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    MOVE,
    DOOR_OPEN
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/elevator_car_controller_call_scanner.sv
// Combinational scan of pending calls relative to the car's floor:
// presence and population above/below, and a call at the floor itself.
module call_scanner
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  here,
  output logic [CNT_W-1:0]      count_above,
  output logic [CNT_W-1:0]      count_below
);

  always_comb begin
    above       = 1'b0;
    below       = 1'b0;
    here        = 1'b0;
    count_above = '0;
    count_below = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i > 32'(floor)) begin
          above       = 1'b1;
          count_above = count_above + CNT_W'(1);
        end else if (i < 32'(floor)) begin
          below       = 1'b1;
          count_below = count_below + CNT_W'(1);
        end else begin
          here = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_car_controller.sv
// Single-car elevator sequencer: call latching, direction choice, travel and door timing.
// Optional ELEVATOR_ESTOP_EN adds an estop input that freezes state, timer and floor.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending_calls,
  output logic                  busy
);

  localparam int unsigned CNT_W   = clog2_min1(NUM_FLOORS + 1);
  localparam int unsigned T_MAX   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W = clog2_min1(T_MAX);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, step_floor, clear_floor;
  logic                    dir_q, dir_d;
  logic                    from_idle_q;
  logic [NUM_FLOORS-1:0]   pending_q, clear_mask;
  logic                    clear_en, hold, step_hit, call_here;
  logic                    above, below, here;
  logic [CNT_W-1:0]        count_above, count_below;

`ifdef ELEVATOR_ESTOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif

  call_scanner #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .CNT_W      (CNT_W)
  ) u_call_scanner (
    .pending     (pending_q),
    .floor       (floor_q),
    .above       (above),
    .below       (below),
    .here        (here),
    .count_above (count_above),
    .count_below (count_below)
  );

  always_comb begin
    step_floor = floor_q;
    if (dir_q == DIR_UP) begin
      if (floor_q != TOP_FLOOR) step_floor = floor_q + FLOOR_W'(1);
    end else begin
      if (floor_q != '0) step_floor = floor_q - FLOOR_W'(1);
    end
  end

  // Arrival test uses the stepped floor; above/below from the old floor stay
  // valid for "still ahead" because the stepped-floor bit is zero in that branch.
  always_comb begin
    step_hit  = 1'b0;
    call_here = here;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (32'(step_floor) == i) step_hit = pending_q[i];
      if (32'(floor_q) == i && call_req[i]) call_here = 1'b1;
    end
  end

  always_comb begin
    clear_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (clear_en && 32'(clear_floor) == i) clear_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    clear_en    = 1'b0;
    clear_floor = floor_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (here) begin
            state_d  = DOOR_OPEN;
            timer_d  = DOOR_LOAD;
            clear_en = 1'b1;
          end else if (|pending_q) begin
            state_d = DECIDE;
          end
        end
        DECIDE: begin
          if (!(|pending_q)) begin
            state_d = IDLE;
          end else if (here) begin
            state_d  = DOOR_OPEN;
            timer_d  = DOOR_LOAD;
            clear_en = 1'b1;
          end else begin
            state_d = MOVE;
            timer_d = TRAVEL_LOAD;
            if (from_idle_q && above && below)
              dir_d = (count_above >= count_below) ? DIR_UP : DIR_DOWN;
            else if ((dir_q == DIR_UP) ? above : below)
              dir_d = dir_q;
            else
              dir_d = ~dir_q;
          end
        end
        MOVE: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TIMER_W'(1);
          end else begin
            floor_d = step_floor;
            if (step_hit) begin
              state_d     = DOOR_OPEN;
              timer_d     = DOOR_LOAD;
              clear_en    = 1'b1;
              clear_floor = step_floor;
            end else if ((dir_q == DIR_UP) ? above : below) begin
              timer_d = TRAVEL_LOAD;
            end else begin
              state_d = DECIDE;
            end
          end
        end
        DOOR_OPEN: begin
          // A call at the open floor is absorbed and restarts the door interval.
          clear_en = 1'b1;
          if (call_here)
            timer_d = DOOR_LOAD;
          else if (timer_q != '0)
            timer_d = timer_q - TIMER_W'(1);
          else
            state_d = DECIDE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      floor_q     <= '0;
      dir_q       <= DIR_UP;
      from_idle_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      from_idle_q <= hold ? from_idle_q : (state_q == IDLE);
      pending_q   <= (pending_q | call_req) & ~clear_mask;
    end
  end

  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign pending_calls = pending_q;
  assign moving        = (state_q == MOVE) && !hold;
  assign door_open     = (state_q == DOOR_OPEN);
  assign busy          = (state_q != IDLE);

endmodule
